// File: rtl/ysyx_25040129_rtc.sv
// AXI4-Lite read-only 64-bit RTC (mtime) with a prescaled tick; writes are rejected with SLVERR.
// Define YSYX_25040129_RTC_SNAPSHOT_EN to latch the high word on low-word reads for tear-free 64-bit access.
//   state  | meaning
//   R_IDLE | accepting a read address
//   R_RESP | holding read data until rready
module ysyx_25040129_rtc #(
  parameter logic [31:0] RTC_BASE = 32'ha000_0048,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [15:0] PRESC_MAX   = 16'(TICK_DIV - 1);

  r_state_t    r_state;
  logic [63:0] mtime;
  logic [15:0] prescaler;
  logic [31:0] hi_word;
  logic        aw_got;
  logic        w_got;
  logic        unused_wr;

  // Write address/data carry no meaning here; the whole write path only returns an error.
  assign unused_wr = ^{awaddr, wdata, wstrb};

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= 64'd0;
      prescaler <= 16'd0;
    end else if (prescaler == PRESC_MAX) begin
      prescaler <= 16'd0;
      mtime     <= mtime + 64'd1;
    end else begin
      prescaler <= prescaler + 16'd1;
    end
  end

`ifdef YSYX_25040129_RTC_SNAPSHOT_EN
  logic [31:0] shadow;
  assign hi_word = shadow;

  always_ff @(posedge clk) begin
    if (rst)
      shadow <= 32'd0;
    else if (r_state == R_IDLE && arvalid && araddr == RTC_BASE)
      shadow <= mtime[63:32];
  end
`else
  assign hi_word = mtime[63:32];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 32'd0;
      rresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_state <= R_RESP;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            if (araddr == RTC_BASE) begin
              rdata <= mtime[31:0];
              rresp <= RESP_OKAY;
            end else if (araddr == RTC_BASE + 32'd4) begin
              rdata <= hi_word;
              rresp <= RESP_OKAY;
            end else begin
              rdata <= 32'd0;
              rresp <= RESP_SLVERR;
            end
          end
        end
        R_RESP: begin
          if (rready) begin
            r_state <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
          end
        end
      endcase
    end
  end

  // AW and W are captured independently; the error response waits for both.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (bvalid) begin
      if (bready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        bvalid <= 1'b0;
      end
    end else if (aw_got && w_got) begin
      bvalid <= 1'b1;
      bresp  <= RESP_SLVERR;
    end else begin
      if (awvalid) aw_got <= 1'b1;
      if (wvalid)  w_got  <= 1'b1;
    end
  end

  assign awready = ~aw_got;
  assign wready  = ~w_got;

endmodule

// File: tb/tb_ysyx_25040129_rtc.sv
// Bench for ysyx_25040129_rtc: two instances (TICK_DIV 1 and 4) share stimulus and are checked
// every cycle against a transaction-level model where mtime = cycles_since_reset / TICK_DIV.
module tb_ysyx_25040129_rtc;
  localparam logic [31:0] BASE = 32'ha000_0048;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic        arvalid = 1'b0, rready = 1'b1, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic [3:0]  wstrb = 4'hf;

  logic        arready_a, rvalid_a, awready_a, wready_a, bvalid_a;
  logic [31:0] rdata_a;
  logic [1:0]  rresp_a, bresp_a;
  logic        arready_b, rvalid_b, awready_b, wready_b, bvalid_b;
  logic [31:0] rdata_b;
  logic [1:0]  rresp_b, bresp_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bhs      = 0;
  logic forced = 1'b0;

  always #5 clk = ~clk;

  ysyx_25040129_rtc #(.RTC_BASE(BASE), .TICK_DIV(1)) dut_a (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_a),
    .rdata(rdata_a), .rresp(rresp_a), .rvalid(rvalid_a), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_a),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_a),
    .bresp(bresp_a), .bvalid(bvalid_a), .bready(bready));

  ysyx_25040129_rtc #(.RTC_BASE(BASE), .TICK_DIV(4)) dut_b (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready_b),
    .rdata(rdata_b), .rresp(rresp_b), .rvalid(rvalid_b), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready_b),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready_b),
    .bresp(bresp_b), .bvalid(bvalid_b), .bready(bready));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: n counts non-reset edges, so mtime = n / TICK_DIV before each edge.
  logic [63:0] n = '0;
  logic        m_rvalid = 1'b0, m_aw = 1'b0, m_w = 1'b0, m_bvalid = 1'b0;
  logic [31:0] m_rdata_a = '0, m_rdata_b = '0, m_sh_a = '0, m_sh_b = '0;
  logic [1:0]  m_rresp = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bvalid_a && bready) bhs <= bhs + 1;
    if (rst) begin
      n <= '0; m_rvalid <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; m_bvalid <= 1'b0;
      m_sh_a <= '0; m_sh_b <= '0;
    end else begin
      n <= n + 64'd1;
      if (m_rvalid) begin
        if (rready) m_rvalid <= 1'b0;
      end else if (arvalid) begin
        m_rvalid <= 1'b1;
        if (araddr == BASE) begin
          m_rdata_a <= n[31:0];
          m_rdata_b <= 32'(n / 64'd4);
          m_sh_a    <= n[63:32];
          m_sh_b    <= 32'((n / 64'd4) >> 32);
          m_rresp   <= 2'b00;
        end else if (araddr == BASE + 32'd4) begin
`ifdef YSYX_25040129_RTC_SNAPSHOT_EN
          m_rdata_a <= m_sh_a;
          m_rdata_b <= m_sh_b;
`else
          m_rdata_a <= n[63:32];
          m_rdata_b <= 32'((n / 64'd4) >> 32);
`endif
          m_rresp <= 2'b00;
        end else begin
          m_rdata_a <= '0;
          m_rdata_b <= '0;
          m_rresp   <= 2'b10;
        end
      end
      if (m_bvalid) begin
        if (bready) begin m_bvalid <= 1'b0; m_aw <= 1'b0; m_w <= 1'b0; end
      end else if (m_aw && m_w) begin
        m_bvalid <= 1'b1;
      end else begin
        if (awvalid) m_aw <= 1'b1;
        if (wvalid)  m_w  <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("arready_a", arready_a, !m_rvalid);
      chk("arready_b", arready_b, !m_rvalid);
      chk("rvalid_a", rvalid_a, m_rvalid);
      chk("rvalid_b", rvalid_b, m_rvalid);
      chk("awready_a", awready_a, !m_aw);
      chk("wready_a", wready_a, !m_w);
      chk("bvalid_a", bvalid_a, m_bvalid);
      chk("bvalid_b", bvalid_b, m_bvalid);
      chk("awready_b", awready_b, !m_aw);
      chk("wready_b", wready_b, !m_w);
      if (m_rvalid) begin
        if (!forced) chk("rdata_a", rdata_a, m_rdata_a);
        chk("rdata_b", rdata_b, m_rdata_b);
        chk("rresp_a", rresp_a, m_rresp);
        chk("rresp_b", rresp_b, m_rresp);
      end
      if (m_bvalid) begin
        chk("bresp_a", bresp_a, 2'b10);
        chk("bresp_b", bresp_b, 2'b10);
      end
    end
  end

  task automatic read_req(input logic [31:0] addr);
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bhs0;
    repeat (3) @(negedge clk);
    chk("reset_arready", arready_a, 1'b1);
    chk("reset_rvalid", rvalid_a, 1'b0);
    chk("reset_rdata", rdata_a, 32'h0);
    chk("reset_rresp", rresp_a, 2'b00);
    chk("reset_awready", awready_a, 1'b1);
    chk("reset_wready", wready_a, 1'b1);
    chk("reset_bvalid", bvalid_a, 1'b0);
    chk("reset_bresp", bresp_a, 2'b00);
    rst = 1'b0;

    // Read low word 10 cycles after reset release.
    repeat (10) @(negedge clk);
    chk("rvalid_before_hs", rvalid_a, 1'b0);
    read_req(BASE);
    chk("rvalid_one_cycle", rvalid_a, 1'b1);
    chk("cyc10_div1", rdata_a, 32'd10);
    chk("cyc10_div4", rdata_b, 32'd2);
    chk("cyc10_rresp", rresp_a, 2'b00);
    @(negedge clk);

    // Prescaled read with rready held low.
    do_reset();
    repeat (40) @(negedge clk);
    rready = 1'b0;
    read_req(BASE);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rdata_div4", rdata_b, 32'd10);
      chk("hold_rvalid_div4", rvalid_b, 1'b1);
      chk("hold_rdata_div1", rdata_a, 32'd40);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("hold_release", rvalid_b, 1'b0);

    // Error addresses, then a good read.
    read_req(BASE + 32'd8);
    chk("err8_rdata", rdata_a, 32'h0);
    chk("err8_rresp", rresp_a, 2'b10);
    @(negedge clk);
    read_req(BASE + 32'd2);
    chk("err2_rdata", rdata_b, 32'h0);
    chk("err2_rresp", rresp_b, 2'b10);
    @(negedge clk);
    read_req(BASE);
    chk("after_err_rresp", rresp_a, 2'b00);
    @(negedge clk);

    // Write rejected: W leads AW by 3 cycles, concurrent read in flight.
    bhs0   = bhs;
    bready = 1'b0;
    wdata  = 32'hDEAD_BEEF;
    wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("w_captured", wready_a, 1'b0);
    repeat (2) @(negedge clk);
    awaddr  = BASE;
    awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("bvalid_not_yet", bvalid_a, 1'b0);
    read_req(BASE);
    chk("wr_bvalid", bvalid_a, 1'b1);
    chk("wr_bresp", bresp_a, 2'b10);
    repeat (2) @(negedge clk);
    bready = 1'b1;
    @(negedge clk);
    chk("wr_bvalid_clear", bvalid_a, 1'b0);
    repeat (3) @(negedge clk);
    chk("wr_one_response", bhs - bhs0, 1);
    read_req(BASE);
    @(negedge clk);

    // Carry across the word boundary on the TICK_DIV=1 instance.
    forced = 1'b1;
    force dut_a.mtime = 64'h0000_0000_FFFF_FFFF;
    read_req(BASE);
    release dut_a.mtime;
    chk("forced_lo", rdata_a, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    read_req(BASE + 32'd4);
`ifdef YSYX_25040129_RTC_SNAPSHOT_EN
    chk("forced_hi_snapshot", rdata_a, 32'd0);
`else
    chk("forced_hi_live", rdata_a, 32'd1);
`endif
    chk("forced_hi_rresp", rresp_a, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    forced = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Reset aborts a pending read and a half-captured write.
    rready = 1'b0;
    wvalid = 1'b1;
    read_req(BASE);
    wvalid = 1'b0;
    chk("abort_pre_rvalid", rvalid_a, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rvalid", rvalid_a, 1'b0);
    chk("abort_arready", arready_a, 1'b1);
    chk("abort_wready", wready_a, 1'b1);
    rst = 1'b0;
    rready = 1'b1;
    read_req(BASE);
    chk("abort_mtime_a", rdata_a, 32'd0);
    chk("abort_mtime_b", rdata_b, 32'd0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25040129_rtc.md
YSYX_25040129_RTC -- requirements
Module: ysyx_25040129_rtc

Interface
REQ-001 SHALL have parameter RTC_BASE, default 32'ha000_0048, byte base address of the 8-byte register window.
REQ-002 SHALL have parameter TICK_DIV, default 1, clk cycles per counter increment (range 1..65535).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports araddr in 32, arvalid in 1, arready out 1: AXI read address channel.
REQ-006 SHALL have ports rdata out 32, rresp out 2, rvalid out 1, rready in 1: AXI read data channel.
REQ-007 SHALL have ports awaddr in 32, awvalid in 1, awready out 1: AXI write address channel.
REQ-008 SHALL have ports wdata in 32, wstrb in 4, wvalid in 1, wready out 1: AXI write data channel.
REQ-009 SHALL have ports bresp out 2, bvalid out 1, bready in 1: AXI write response channel.

Function
REQ-010 SHALL keep a 64-bit counter mtime; prescaler counts 0..TICK_DIV-1, mtime increments by 1 when prescaler = TICK_DIV-1; mtime wraps from all-ones to 0.
REQ-011 Read FSM SHALL have states R_IDLE and R_RESP; arready = 1 only in R_IDLE; rvalid = 1 only in R_RESP.
REQ-012 On arvalid && arready: SHALL capture response data and go to R_RESP; rvalid asserts exactly one cycle after the handshake.
REQ-013 Read data SHALL reflect mtime value registered in the handshake cycle (before that cycle's increment).
REQ-014 araddr = RTC_BASE+0 -> rdata = mtime[31:0], rresp 2'b00; araddr = RTC_BASE+4 -> high word per REQ-024/025, rresp 2'b00.
REQ-015 Any other araddr (outside window or not word-aligned) -> rdata 32'h0, rresp 2'b10 (SLVERR); no side effect on shadow.
REQ-016 rdata/rresp/rvalid SHALL hold stable in R_RESP until rready; on rvalid && rready go to R_IDLE; no new AR accepted in that same cycle.
REQ-017 Write path is read-only rejection: awready = 1 until AW captured, wready = 1 until W captured; AW and W accepted in any order or same cycle.
REQ-018 Once both AW and W captured, bvalid SHALL assert next cycle with bresp 2'b10, held until bready; on bvalid && bready clear both captures; mtime never modified by writes.
REQ-019 Read and write paths SHALL operate independently and concurrently.
REQ-020 No combinational path from any input to any output.

Reset
REQ-021 While rst = 1: mtime = 0, prescaler = 0, read FSM = R_IDLE, write captures cleared, high shadow = 0.
REQ-022 Reset values: arready = 1, rvalid = 0, rdata = 0, rresp = 0, awready = 1, wready = 1, bvalid = 0, bresp = 0.
REQ-023 rst asserted mid-transaction SHALL abort it; first post-reset cycle behaves as REQ-021/022, no pending response.

Configuration
REQ-024 With YSYX_25040129_RTC_SNAPSHOT_EN defined: a successful read of RTC_BASE+0 latches mtime[63:32] (same sample as REQ-013) into a shadow; read of RTC_BASE+4 returns the shadow, giving tear-free 64-bit reads low-then-high.
REQ-025 Without YSYX_25040129_RTC_SNAPSHOT_EN: no shadow register; read of RTC_BASE+4 returns live mtime[63:32] sampled per REQ-013.

Verification
REQ-026 TICK_DIV=1, reset, read BASE+0 at cycle 10 after reset release -> rvalid one cycle later, rdata = 10, rresp 00.
REQ-027 TICK_DIV=4, read BASE+0 after 40 cycles -> rdata = 10; rready held low 5 cycles -> rdata/rvalid stable throughout.
REQ-028 Force mtime = 64'h0000_0000_FFFF_FFFF, read BASE+0 then 3 cycles later BASE+4 -> with SNAPSHOT_EN high = 0; without = 1.
REQ-029 Read BASE+8 and BASE+2 -> rdata 0, rresp 10 each; subsequent BASE+0 read succeeds with rresp 00.
REQ-030 W before AW by 3 cycles, wdata 32'hDEAD_BEEF -> bvalid once after both, bresp 10; mtime continues counting unaffected.
REQ-031 Assert rst while rvalid = 1 and rready = 0 -> next cycle rvalid = 0, arready = 1, mtime = 0.
